hazard_forward_unit: RTL
========================

Name: hazard_forward_unit

Overview:
- Parametrised successor to the pipeline's operand-forwarding logic.
- Combines the following into one stage-control block between ID and EX of the pipelined TSC core:
  - registered forward-select generation for two source operands;
  - load-use stall sequencing with configurable load latency;
  - branch/jump flush sequencing;
  - halt freeze;
  - saturating hazard performance counters.

Parameters:
- REG_ADDR_W, 2, register-specifier width.
- LOAD_LAT, 1, load-use stall cycles (1..15).
- FLUSH_CYCLES, 1, cycles flush_id is held after a redirect (1..15).
- ZERO_REG_EN, 0, if 1 register 0 is hard-wired: rd==0 never causes a hazard or a forward.
- CNT_W, 16, performance counter width.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset_n  in  1  synchronous, active-high reset (asserted when 1).
- id_rs1  in  REG_ADDR_W  ID-stage source 1.
- id_rs2  in  REG_ADDR_W  ID-stage source 2.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2.
- ex_rd  in  REG_ADDR_W  EX-stage destination.
- ex_reg_write  in  1  EX-stage register write.
- ex_mem_read  in  1  EX-stage instruction is a load.
- mem_rd  in  REG_ADDR_W  MEM-stage destination.
- mem_reg_write  in  1  MEM-stage register write.
- redirect  in  1  EX resolved a taken branch/jump this cycle.
- halt_in  in  1  HLT reached EX this cycle.
- forward_A  out  2  registered source-1 select: 0 regfile, 1 MEM/WB, 2 EX/MEM.
- forward_B  out  2  registered source-2 select, same encoding.
- stall_if  out  1  hold PC.
- stall_id  out  1  hold IF/ID.
- bubble_ex  out  1  insert NOP into ID/EX.
- flush_id  out  1  squash IF/ID.
- halted  out  1  core frozen.
- stall_cnt  out  CNT_W  cycles with load-use stall asserted.
- flush_cnt  out  CNT_W  cycles with flush_id asserted.

Behaviour:
- Match definitions:
  - match(s, rd, we) = we & (s==rd) & !(ZERO_REG_EN & rd==0).
  - hazard = ex_mem_read & match(id_rs1,ex_rd,ex_reg_write) & id_use_rs1, OR the same term for rs2.
- Reset (reset_n=1 at edge):
  - state=RUN; forward_A=forward_B=0; stall_cnt=flush_cnt=0; halted=0; internal counter=0.
  - Combinational outputs are 0 in the reset cycle.
  - Reset mid-stall, mid-flush or in HALT returns to RUN immediately.
- FSM states: RUN, LSTALL, FLUSH, HALT. Priority each cycle: reset > halt_in > redirect > hazard.
- RUN:
  - halt_in: stall_if=1, bubble_ex=1 this cycle; next state HALT.
  - else redirect: flush_id=1, bubble_ex=1 this cycle; next state FLUSH with cnt=FLUSH_CYCLES-1 if FLUSH_CYCLES>1, else RUN.
  - else hazard: stall_if=stall_id=bubble_ex=1 this cycle; next state LSTALL with cnt=LOAD_LAT-1 if LOAD_LAT>1, else RUN.
  - else all control outputs 0.
- LSTALL:
  - stall_if=stall_id=bubble_ex=1; cnt decrements; leave to RUN when cnt==1 at the edge.
  - redirect aborts the stall: flush_id=1, stall outputs 0, go to FLUSH/RUN as above.
  - halt_in goes to HALT.
- FLUSH:
  - flush_id=1, bubble_ex=1; cnt decrements; RUN when cnt reaches 0.
  - A new redirect reloads cnt=FLUSH_CYCLES-1.
- HALT:
  - halted=1, stall_if=stall_id=1, bubble_ex=1; remains until reset.
- Forward registers, updated each edge:
  - If stall_id=1, bubble_ex=1 or flush_id=1: load 0 (bubble entering EX).
  - Else forward_A <= 2 if match(id_rs1,ex_rd,ex_reg_write) & id_use_rs1; else 1 if match(id_rs1,mem_rd,mem_reg_write) & id_use_rs1; else 0.
  - EX/MEM has priority over MEM/WB. forward_B identical using id_rs2/id_use_rs2.
  - Latency: a select is visible exactly one cycle after the instruction leaves ID.
- Counters:
  - stall_cnt +1 on each cycle the load-use stall is asserted (RUN-hazard or LSTALL); flush_cnt +1 on each cycle flush_id=1.
  - Both saturate at all-ones, never wrap. HALT cycles are not counted.

Test Plan:
- Reset: reset_n=1 for 2 cycles with hazard inputs active -> all outputs 0, counters 0, state RUN.
- Double forward: ex_rd=1, ex_reg_write=1, mem_rd=1, mem_reg_write=1, id_rs1=1, id_use_rs1=1 -> forward_A=2 next cycle. Drop ex_reg_write -> forward_A=1. ZERO_REG_EN=1 with rd=0 -> forward_A=0.
- Load-use with LOAD_LAT=3: ex_mem_read=1, ex_rd=2, id_rs2=2, id_use_rs2=1 -> stall_if/stall_id/bubble_ex high exactly 3 cycles, stall_cnt=3, forward_B=0 during the stall.
- Redirect in 2nd LSTALL cycle, FLUSH_CYCLES=2 -> stall drops that cycle, flush_id high 2 cycles, flush_cnt=2.
- halt_in with simultaneous redirect -> halted=1 from next cycle, flush_id=0, state held 20 cycles until reset; reset clears halted.
- CNT_W=4: 20 back-to-back hazard cycles -> stall_cnt saturates at 15.

Source files
------------

// File: rtl/hazard_forward_unit.sv
// ID/EX stage control for the pipelined TSC core: registered operand-forward selects,
// load-use stall, branch flush and halt sequencing, plus saturating hazard counters.
module hazard_forward_unit #(
    parameter int REG_ADDR_W   = 2,
    parameter int LOAD_LAT     = 1,
    parameter int FLUSH_CYCLES = 1,
    parameter int ZERO_REG_EN  = 0,
    parameter int CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_reg_write,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_reg_write,
    input  logic                  redirect,
    input  logic                  halt_in,
    output logic [1:0]            forward_A,
    output logic [1:0]            forward_B,
    output logic                  stall_if,
    output logic                  stall_id,
    output logic                  bubble_ex,
    output logic                  flush_id,
    output logic                  halted,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    typedef enum logic [1:0] {RUN, LSTALL, FLUSH, HALT} state_t;

    localparam logic [3:0]       LOAD_RELOAD  = 4'(LOAD_LAT - 1);
    localparam logic [3:0]       FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};

    state_t            state_r, state_nxt_s;
    logic [3:0]        cnt_r, cnt_nxt_s;
    logic [1:0]        forward_a_r, forward_b_r;
    logic [CNT_W-1:0]  stall_cnt_r, flush_cnt_r;
    logic              stall_if_s, stall_id_s, bubble_ex_s, flush_id_s, halted_s;
    logic              load_stall_s, hazard_s;

    // Register 0 never produces a dependency when it is hard-wired.
    function automatic logic reg_match(input logic [REG_ADDR_W-1:0] src,
                                       input logic [REG_ADDR_W-1:0] rd,
                                       input logic                  we);
        return we && (src == rd) &&
               !((ZERO_REG_EN != 0) && (rd == {REG_ADDR_W{1'b0}}));
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] src,
                                           input logic                  use_src);
        if (use_src && reg_match(src, ex_rd, ex_reg_write)) begin
            return 2'd2;
        end else if (use_src && reg_match(src, mem_rd, mem_reg_write)) begin
            return 2'd1;
        end else begin
            return 2'd0;
        end
    endfunction

    // Load-use hazard detection against the instruction currently in EX.
    always_comb begin
        hazard_s = ex_mem_read &&
                   ((id_use_rs1 && reg_match(id_rs1, ex_rd, ex_reg_write)) ||
                    (id_use_rs2 && reg_match(id_rs2, ex_rd, ex_reg_write)));
    end

    // Next-state and control outputs; halt beats redirect beats hazard.
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = cnt_r;
        stall_if_s   = 1'b0;
        stall_id_s   = 1'b0;
        bubble_ex_s  = 1'b0;
        flush_id_s   = 1'b0;
        halted_s     = 1'b0;
        load_stall_s = 1'b0;
        if (reset_n) begin
            state_nxt_s = RUN;
            cnt_nxt_s   = 4'd0;
        end else if (state_r == HALT) begin
            halted_s    = 1'b1;
            stall_if_s  = 1'b1;
            stall_id_s  = 1'b1;
            bubble_ex_s = 1'b1;
        end else if (halt_in) begin
            stall_if_s  = 1'b1;
            bubble_ex_s = 1'b1;
            state_nxt_s = HALT;
            cnt_nxt_s   = 4'd0;
        end else if (redirect) begin
            flush_id_s  = 1'b1;
            bubble_ex_s = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_nxt_s = FLUSH;
                cnt_nxt_s   = FLUSH_RELOAD;
            end else begin
                state_nxt_s = RUN;
                cnt_nxt_s   = 4'd0;
            end
        end else begin
            case (state_r)
                RUN: begin
                    if (hazard_s) begin
                        stall_if_s   = 1'b1;
                        stall_id_s   = 1'b1;
                        bubble_ex_s  = 1'b1;
                        load_stall_s = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_nxt_s = LSTALL;
                            cnt_nxt_s   = LOAD_RELOAD;
                        end else begin
                            state_nxt_s = RUN;
                        end
                    end else begin
                        state_nxt_s = RUN;
                    end
                end
                LSTALL: begin
                    stall_if_s   = 1'b1;
                    stall_id_s   = 1'b1;
                    bubble_ex_s  = 1'b1;
                    load_stall_s = 1'b1;
                    cnt_nxt_s    = cnt_r - 4'd1;
                    if (cnt_r <= 4'd1) begin
                        state_nxt_s = RUN;
                    end else begin
                        state_nxt_s = LSTALL;
                    end
                end
                FLUSH: begin
                    flush_id_s  = 1'b1;
                    bubble_ex_s = 1'b1;
                    cnt_nxt_s   = cnt_r - 4'd1;
                    if (cnt_r <= 4'd1) begin
                        state_nxt_s = RUN;
                    end else begin
                        state_nxt_s = FLUSH;
                    end
                end
                default: begin
                    state_nxt_s = RUN;
                    cnt_nxt_s   = 4'd0;
                end
            endcase
        end
    end

    // State, forward selects and saturating counters.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            state_r     <= RUN;
            cnt_r       <= 4'd0;
            forward_a_r <= 2'd0;
            forward_b_r <= 2'd0;
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            // A bubble or squashed instruction entering EX must not forward.
            if (stall_id_s || bubble_ex_s || flush_id_s) begin
                forward_a_r <= 2'd0;
                forward_b_r <= 2'd0;
            end else begin
                forward_a_r <= fwd_sel(id_rs1, id_use_rs1);
                forward_b_r <= fwd_sel(id_rs2, id_use_rs2);
            end
            if (load_stall_s && (stall_cnt_r != CNT_MAX)) begin
                stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (flush_id_s && (flush_cnt_r != CNT_MAX)) begin
                flush_cnt_r <= flush_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign forward_A = forward_a_r;
    assign forward_B = forward_b_r;
    assign stall_if  = stall_if_s;
    assign stall_id  = stall_id_s;
    assign bubble_ex = bubble_ex_s;
    assign flush_id  = flush_id_s;
    assign halted    = halted_s;
    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;

endmodule
